dsi_axil_arbiter: RTL and testbench

Two-master AXI4-Lite arbiter that shares the single configuration port of `dsi_tx` between the panel initialisation sequencer (`panel_config`, master 0) and a runtime command master (master 1, e.g. brightness or debug register access). It sits in the `i_fb_clk` domain, between both masters and the DSI TX `axi_*` slave port. It serialises one transaction at a time, uses round-robin between masters, and can lock out master 1 until panel configuration is done. An optional watchdog aborts a hung slave transaction.

---
 rtl/dsi_axil_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dsi_axil_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_axil_arbiter.sv
// dsi_axil_arbiter: two-master AXI4-Lite arbiter in front of the dsi_tx config port.
// Master 0 is the panel init sequencer, master 1 the runtime command master.
// One transaction at a time, round-robin on ties, master 1 can be locked out.
// Optional watchdog abort is enabled with `define DSI_AXIL_ARB_TIMEOUT_EN.
module dsi_axil_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              i_axi_clk,
    input  logic              i_srst,
    input  logic              i_m1_lock,
    // master 0
    input  logic [ADDR_W-1:0] i_m0_awaddr,
    input  logic              i_m0_awvalid,
    output logic              o_m0_awready,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic              i_m0_wvalid,
    output logic              o_m0_wready,
    output logic              o_m0_bvalid,
    input  logic              i_m0_bready,
    input  logic [ADDR_W-1:0] i_m0_araddr,
    input  logic              i_m0_arvalid,
    output logic              o_m0_arready,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_rvalid,
    input  logic              i_m0_rready,
    // master 1
    input  logic [ADDR_W-1:0] i_m1_awaddr,
    input  logic              i_m1_awvalid,
    output logic              o_m1_awready,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic              i_m1_wvalid,
    output logic              o_m1_wready,
    output logic              o_m1_bvalid,
    input  logic              i_m1_bready,
    input  logic [ADDR_W-1:0] i_m1_araddr,
    input  logic              i_m1_arvalid,
    output logic              o_m1_arready,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_rvalid,
    input  logic              i_m1_rready,
    // slave (dsi_tx axi_*)
    output logic [ADDR_W-1:0] o_s_awaddr,
    output logic              o_s_awvalid,
    input  logic              i_s_awready,
    output logic [DATA_W-1:0] o_s_wdata,
    output logic              o_s_wvalid,
    input  logic              i_s_wready,
    input  logic              i_s_bvalid,
    output logic              o_s_bready,
    output logic [ADDR_W-1:0] o_s_araddr,
    output logic              o_s_arvalid,
    input  logic              i_s_arready,
    input  logic [DATA_W-1:0] i_s_rdata,
    input  logic              i_s_rvalid,
    output logic              o_s_rready,
    // status
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic [2:0] {
        IDLE, ARB, WR, WRESP, RD, RDATA, ABORT_W, ABORT_R
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant_nxt;
    logic        last, last_nxt;
    logic [1:0]  req, req_q;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs;
    logic        pick;

    // owner-side view of the currently granted master
    logic              sel;
    logic [ADDR_W-1:0] m_awaddr, m_araddr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

    // master-facing response signals before demux to the owner
    logic              awready_c, wready_c, bvalid_c, arready_c, rvalid_c;
    logic [DATA_W-1:0] rdata_c;

    assign req[0] = i_m0_awvalid | i_m0_arvalid;
    assign req[1] = (i_m1_awvalid | i_m1_arvalid) & ~i_m1_lock;

    assign sel       = o_grant[1];
    assign m_awaddr  = sel ? i_m1_awaddr  : i_m0_awaddr;
    assign m_awvalid = sel ? i_m1_awvalid : i_m0_awvalid;
    assign m_wdata   = sel ? i_m1_wdata   : i_m0_wdata;
    assign m_wvalid  = sel ? i_m1_wvalid  : i_m0_wvalid;
    assign m_bready  = sel ? i_m1_bready  : i_m0_bready;
    assign m_araddr  = sel ? i_m1_araddr  : i_m0_araddr;
    assign m_arvalid = sel ? i_m1_arvalid : i_m0_arvalid;
    assign m_rready  = sel ? i_m1_rready  : i_m0_rready;

`ifdef DSI_AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
`endif

    // next-state, grant and channel passthrough
    always_comb begin
        state_nxt   = state;
        grant_nxt   = o_grant;
        last_nxt    = last;
        pick        = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        o_s_awaddr  = '0;
        o_s_awvalid = 1'b0;
        o_s_wdata   = '0;
        o_s_wvalid  = 1'b0;
        o_s_bready  = 1'b0;
        o_s_araddr  = '0;
        o_s_arvalid = 1'b0;
        o_s_rready  = 1'b0;
        awready_c   = 1'b0;
        wready_c    = 1'b0;
        bvalid_c    = 1'b0;
        arready_c   = 1'b0;
        rvalid_c    = 1'b0;
        rdata_c     = '0;
`ifdef DSI_AXIL_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: if (|req) state_nxt = ARB;
            ARB: begin
                // on a tie the master not served last wins; last=1 after reset
                pick      = (req_q == 2'b11) ? ~last : req_q[1];
                grant_nxt = pick ? 2'b10 : 2'b01;
                state_nxt = (pick ? i_m1_awvalid : i_m0_awvalid) ? WR : RD;
            end
            WR: begin
                // a channel that already handshook stops presenting valid
                o_s_awaddr  = m_awaddr;
                o_s_awvalid = m_awvalid & ~aw_done;
                awready_c   = i_s_awready & ~aw_done;
                o_s_wdata   = m_wdata;
                o_s_wvalid  = m_wvalid & ~w_done;
                wready_c    = i_s_wready & ~w_done;
                aw_hs       = o_s_awvalid & i_s_awready;
                w_hs        = o_s_wvalid & i_s_wready;
                if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WRESP;
            end
            WRESP: begin
                o_s_bready = m_bready;
                bvalid_c   = i_s_bvalid;
                if (i_s_bvalid && m_bready) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    last_nxt  = sel;
                end
            end
            RD: begin
                o_s_araddr  = m_araddr;
                o_s_arvalid = m_arvalid;
                arready_c   = i_s_arready;
                if (m_arvalid && i_s_arready) state_nxt = RDATA;
            end
            RDATA: begin
                o_s_rready = m_rready;
                rvalid_c   = i_s_rvalid;
                rdata_c    = i_s_rdata;
                if (i_s_rvalid && m_rready) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    last_nxt  = sel;
                end
            end
`ifdef DSI_AXIL_ARB_TIMEOUT_EN
            ABORT_W: begin
                bvalid_c = 1'b1;
                if (m_bready) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    last_nxt  = sel;
                end
            end
            ABORT_R: begin
                rvalid_c = 1'b1;
                rdata_c  = DATA_W'(32'hDEADBEEF);
                if (m_rready) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    last_nxt  = sel;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
`ifdef DSI_AXIL_ARB_TIMEOUT_EN
        // watchdog: cut the slave off and hand the owner a fake response
        if ((state inside {WR, WRESP, RD, RDATA}) && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            o_s_awvalid = 1'b0;
            o_s_wvalid  = 1'b0;
            o_s_arvalid = 1'b0;
            o_s_bready  = 1'b0;
            o_s_rready  = 1'b0;
            awready_c   = 1'b0;
            wready_c    = 1'b0;
            bvalid_c    = 1'b0;
            arready_c   = 1'b0;
            rvalid_c    = 1'b0;
            rdata_c     = '0;
            aw_hs       = 1'b0;
            w_hs        = 1'b0;
            grant_nxt   = o_grant;
            last_nxt    = last;
            state_nxt   = (state == WR || state == WRESP) ? ABORT_W : ABORT_R;
        end
`endif
    end

    // state, grant, round-robin pointer and write-channel flags
    always_ff @(posedge i_axi_clk) begin
        if (i_srst) begin
            state   <= IDLE;
            o_grant <= 2'b00;
            last    <= 1'b1;
            req_q   <= 2'b00;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_grant <= grant_nxt;
            last    <= last_nxt;
            if (state == IDLE) req_q <= req;
            aw_done <= (state_nxt == WR) ? (aw_done | aw_hs) : 1'b0;
            w_done  <= (state_nxt == WR) ? (w_done | w_hs) : 1'b0;
        end
    end

`ifdef DSI_AXIL_ARB_TIMEOUT_EN
    // watchdog counter restarts on every state change; timeout pulse lands on abort entry
    always_ff @(posedge i_axi_clk) begin
        if (i_srst) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
            o_timeout <= timeout_hit;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

    assign o_m0_awready = o_grant[0] & awready_c;
    assign o_m0_wready  = o_grant[0] & wready_c;
    assign o_m0_bvalid  = o_grant[0] & bvalid_c;
    assign o_m0_arready = o_grant[0] & arready_c;
    assign o_m0_rvalid  = o_grant[0] & rvalid_c;
    assign o_m0_rdata   = o_grant[0] ? rdata_c : '0;
    assign o_m1_awready = o_grant[1] & awready_c;
    assign o_m1_wready  = o_grant[1] & wready_c;
    assign o_m1_bvalid  = o_grant[1] & bvalid_c;
    assign o_m1_arready = o_grant[1] & arready_c;
    assign o_m1_rvalid  = o_grant[1] & rvalid_c;
    assign o_m1_rdata   = o_grant[1] ? rdata_c : '0;

endmodule

// File: tb/tb_dsi_axil_arbiter.sv
// tb_dsi_axil_arbiter: table-driven transactions with a scoreboard, plus
// hand-written tie/alternation, lock and (optional) watchdog sequences.
module tb_dsi_axil_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;
`ifdef DSI_AXIL_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic srst = 1'b1;
    logic lock = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] m_awaddr[2], m_araddr[2];
    logic [DW-1:0] m_wdata[2];
    logic          m_awvalid[2], m_wvalid[2], m_bready[2], m_arvalid[2], m_rready[2];
    logic          mo_awready[2], mo_wready[2], mo_bvalid[2], mo_arready[2], mo_rvalid[2];
    logic [DW-1:0] mo_rdata[2];

    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]    grant;
    logic          timeout;

    dsi_axil_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_axi_clk(clk), .i_srst(srst), .i_m1_lock(lock),
        .i_m0_awaddr(m_awaddr[0]), .i_m0_awvalid(m_awvalid[0]), .o_m0_awready(mo_awready[0]),
        .i_m0_wdata(m_wdata[0]), .i_m0_wvalid(m_wvalid[0]), .o_m0_wready(mo_wready[0]),
        .o_m0_bvalid(mo_bvalid[0]), .i_m0_bready(m_bready[0]),
        .i_m0_araddr(m_araddr[0]), .i_m0_arvalid(m_arvalid[0]), .o_m0_arready(mo_arready[0]),
        .o_m0_rdata(mo_rdata[0]), .o_m0_rvalid(mo_rvalid[0]), .i_m0_rready(m_rready[0]),
        .i_m1_awaddr(m_awaddr[1]), .i_m1_awvalid(m_awvalid[1]), .o_m1_awready(mo_awready[1]),
        .i_m1_wdata(m_wdata[1]), .i_m1_wvalid(m_wvalid[1]), .o_m1_wready(mo_wready[1]),
        .o_m1_bvalid(mo_bvalid[1]), .i_m1_bready(m_bready[1]),
        .i_m1_araddr(m_araddr[1]), .i_m1_arvalid(m_arvalid[1]), .o_m1_arready(mo_arready[1]),
        .o_m1_rdata(mo_rdata[1]), .o_m1_rvalid(mo_rvalid[1]), .i_m1_rready(m_rready[1]),
        .o_s_awaddr(s_awaddr), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(s_wdata), .o_s_wvalid(s_wvalid), .i_s_wready(s_wready),
        .i_s_bvalid(s_bvalid), .o_s_bready(s_bready),
        .o_s_araddr(s_araddr), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
        .i_s_rdata(s_rdata), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
        .o_grant(grant), .o_timeout(timeout)
    );

    wire any_out = |{s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
                     mo_awready[0], mo_wready[0], mo_bvalid[0], mo_arready[0], mo_rvalid[0], mo_rdata[0],
                     mo_awready[1], mo_wready[1], mo_bvalid[1], mo_arready[1], mo_rvalid[1], mo_rdata[1],
                     grant, timeout};

    typedef struct {
        int            m;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            aw_dly;   // cycle (from request) at which slave AW/AR ready rises
        int            w_dly;    // cycle at which slave W ready rises
        int            rsp_dly;  // cycles between response phase entry and slave B/R valid
        logic [1:0]    grant;
    } vec_t;

    typedef struct {
        logic [1:0]    grant;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] exp_g[$];
    vec_t       vecs[6];
    int         nvec = 0;
    int         nerr = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = '0; m_araddr[i] = '0; m_wdata[i] = '0;
            m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0; m_arvalid[i] = 1'b0;
            m_bready[i] = 1'b1; m_rready[i] = 1'b1;
        end
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        lock = 1'b0;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                m_awaddr[i] = AW'($urandom); m_araddr[i] = AW'($urandom); m_wdata[i] = $urandom;
                m_awvalid[i] = 1'($urandom); m_wvalid[i] = 1'($urandom); m_arvalid[i] = 1'($urandom);
                m_bready[i] = 1'($urandom); m_rready[i] = 1'($urandom);
            end
            s_awready = 1'($urandom); s_wready = 1'($urandom); s_bvalid = 1'($urandom);
            s_arready = 1'($urandom); s_rvalid = 1'($urandom); s_rdata = $urandom;
            lock = 1'($urandom);
            #1;
            chk("reset_outputs_zero", any_out, 0);
            chk("reset_grant", grant, 0);
        end
        clear_inputs();
        srst = 1'b0;
    endtask

    // one transaction from an idle arbiter, slave model driven from the vector's delays
    task automatic do_txn(input vec_t v);
        int   aw_n = 0, w_n = 0, ar_n = 0;
        int   first_c = -1, done_c = 1000, other_bad = 0, early_rsp = 0;
        bit   fin = 0, aw_hs, w_hs, ar_hs;
        int   o = 1 - v.m;
        exp_t e;
        @(negedge clk);
        s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
        if (v.wr) begin
            m_awaddr[v.m] = v.addr; m_awvalid[v.m] = 1'b1;
            m_wdata[v.m] = v.data;  m_wvalid[v.m] = 1'b1;
        end else begin
            m_araddr[v.m] = v.addr; m_arvalid[v.m] = 1'b1;
        end
        e.grant = v.grant; e.addr = v.addr; e.data = v.data;
        sb.push_back(e);
        for (int c = 0; c < 60 && !fin; c++) begin
            s_awready = (c >= v.aw_dly);
            s_wready  = (c >= v.w_dly);
            s_arready = (c >= v.aw_dly);
            s_bvalid  = v.wr && (c >= done_c + v.rsp_dly);
            s_rvalid  = !v.wr && (c >= done_c + v.rsp_dly);
            s_rdata   = s_rvalid ? v.data : '0;
            #1;
            if (first_c < 0 && (s_awvalid || s_arvalid)) first_c = c;
            if (c < done_c && (s_bready || s_rready)) early_rsp++;
            if (mo_awready[o] | mo_wready[o] | mo_bvalid[o] | mo_arready[o] | mo_rvalid[o] | (|mo_rdata[o]))
                other_bad++;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            ar_hs = s_arvalid && s_arready;
            if (aw_hs) begin
                aw_n++;
                chk("aw_addr", s_awaddr, sb[0].addr);
                chk("aw_grant", grant, sb[0].grant);
            end
            if (w_hs) begin
                w_n++;
                chk("w_data", s_wdata, sb[0].data);
            end
            if (ar_hs) begin
                ar_n++;
                chk("ar_addr", s_araddr, sb[0].addr);
                chk("ar_grant", grant, sb[0].grant);
            end
            if (v.wr && c >= done_c) chk("bvalid_follow", mo_bvalid[v.m], s_bvalid);
            if (!v.wr && c >= done_c) chk("rvalid_follow", mo_rvalid[v.m], s_rvalid);
            if (s_bvalid && s_bready) begin
                e = sb.pop_front();
                fin = 1;
            end
            if (s_rvalid && s_rready) begin
                chk("r_data", mo_rdata[v.m], sb[0].data);
                e = sb.pop_front();
                fin = 1;
            end
            if (done_c == 1000 && ((v.wr && aw_n > 0 && w_n > 0) || (!v.wr && ar_n > 0)))
                done_c = c + 1;
            @(negedge clk);
            if (aw_hs) m_awvalid[v.m] = 1'b0;
            if (w_hs)  m_wvalid[v.m]  = 1'b0;
            if (ar_hs) m_arvalid[v.m] = 1'b0;
        end
        chk("txn_complete", fin, 1);
        chk("grant_latency", first_c, 2);
        chk("early_response", early_rsp, 0);
        chk("other_master_quiet", other_bad, 0);
        if (v.wr) begin
            chk("aw_handshakes", aw_n, 1);
            chk("w_handshakes", w_n, 1);
        end else begin
            chk("ar_handshakes", ar_n, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] prev, eg;
        int         bad, found;
        vecs[0] = '{0, 1'b1, 7'h04, 32'h12345678, 0, 0, 0, 2'b01};
        vecs[1] = '{1, 1'b1, 7'h10, 32'hA5A50001, 0, 0, 2, 2'b10};
        vecs[2] = '{0, 1'b0, 7'h08, 32'hCAFEF00D, 0, 0, 1, 2'b01};
        vecs[3] = '{1, 1'b0, 7'h7C, 32'h0000BEEF, 3, 0, 0, 2'b10};
        vecs[4] = '{0, 1'b1, 7'h20, 32'h55AA55AA, 2, 5, 1, 2'b01};
        vecs[5] = '{1, 1'b1, 7'h3C, 32'h00000001, 4, 1, 0, 2'b10};

        clear_inputs();
        do_reset();
        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // tie: both masters stream writes, grants must alternate starting at m0
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) exp_g.push_back((k % 2) ? 2'b10 : 2'b01);
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = AW'(8 + i); m_wdata[i] = 32'h100 + i;
            m_awvalid[i] = 1'b1; m_wvalid[i] = 1'b1;
        end
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        prev = 2'b00;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (grant != 2'b00 && prev == 2'b00 && exp_g.size() > 0) begin
                eg = exp_g.pop_front();
                chk("tie_grant", grant, eg);
            end
            prev = grant;
            @(negedge clk);
        end
        chk("tie_grants_seen", exp_g.size(), 0);

        // lock: m1 requesting but locked out for 100 cycles
        do_reset();
        @(negedge clk);
        lock = 1'b1;
        m_awaddr[1] = 7'h44; m_wdata[1] = 32'h0BADF00D;
        m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (grant != 2'b00) bad++;
        end
        chk("lock_no_grant", bad, 0);
        @(negedge clk);
        lock = 1'b0;
        found = -1;
        for (int c = 0; c < 10 && found < 0; c++) begin
            #1;
            if (grant == 2'b10) found = c;
            else @(negedge clk);
        end
        chk("unlock_grant_latency", found, 2);
        @(negedge clk);
        m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("unlock_txn_done", grant, 0);

`ifdef DSI_AXIL_ARB_TIMEOUT_EN
        // watchdog: m1 read, slave never accepts AR
        begin
            int rd_c, to_c;
            do_reset();
            @(negedge clk);
            m_araddr[1] = 7'h30; m_arvalid[1] = 1'b1;
            rd_c = -1; to_c = -1;
            for (int c = 0; c < 60 && to_c < 0; c++) begin
                #1;
                if (rd_c < 0 && s_arvalid) rd_c = c;
                if (timeout) to_c = c;
                else @(negedge clk);
            end
            chk("timeout_delay", to_c - rd_c, 16);
            chk("abort_rvalid", mo_rvalid[1], 1);
            chk("abort_rdata", mo_rdata[1], 32'hDEADBEEF);
            chk("abort_slave_quiet", s_arvalid, 0);
            @(negedge clk);
            m_arvalid[1] = 1'b0;
            #1;
            chk("timeout_pulse_single", timeout, 0);
            do_txn(vecs[0]);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
